wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline boundary: consumes the WB-stage bundle
//  (alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W, rd_wren_W).

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/wb_regfile_if.sv | 40 ++++
 rtl/wb_mux.sv | 25 ++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: write-back source select and default datapath sizes.
// Imported by the write-back register file, its write-back mux and its bus interface.
package pipeline_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    // Name of the write-back source, handy in bench messages and assertions.
    function automatic string wb_sel_name(input wb_sel_e sel);
        string s;
        case (sel)
            WB_ALU:  s = "ALU";
            WB_MEM:  s = "MEM";
            WB_PC4:  s = "PC4";
            default: s = "RSV";
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, the ID read ports and the register file.
// The WB bundle has no backpressure: rd_wren_W qualifies the bundle each cycle and is always accepted.
interface wb_regfile_if
    import pipeline_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  alu_data_W;
    logic [XLEN-1:0]  read_data_W;
    logic [XLEN-1:0]  pc_four_W;
    logic [AW-1:0]    rd_addr_W;
    wb_sel_e          wb_sel_W;
    logic             rd_wren_W;

    logic [AW-1:0]    rs1_addr_D;
    logic [AW-1:0]    rs2_addr_D;
    logic [XLEN-1:0]  rs1_data_D;
    logic [XLEN-1:0]  rs2_data_D;

    logic [XLEN-1:0]  wb_data_W;
    logic             wb_commit_W;
    logic [CNT_W-1:0] commit_cnt;

    modport master (
        output alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W, rd_wren_W,
        output rs1_addr_D, rs2_addr_D,
        input  rs1_data_D, rs2_data_D, wb_data_W, wb_commit_W, commit_cnt
    );

    modport slave (
        input  alu_data_W, read_data_W, pc_four_W, rd_addr_W, wb_sel_W, rd_wren_W,
        input  rs1_addr_D, rs2_addr_D,
        output rs1_data_D, rs2_data_D, wb_data_W, wb_commit_W, commit_cnt
    );

endinterface

// File: rtl/wb_mux.sv
// Combinational write-back source select; shared with the forwarding path.
// The reserved select code yields zero.
module wb_mux
    import pipeline_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  wb_sel_e         sel_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] mem_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (sel_i)
            WB_ALU:  data_o = alu_i;
            WB_MEM:  data_o = mem_i;
            WB_PC4:  data_o = pc4_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: selects the WB value, commits it, serves two ID read ports
// and counts committed writes. Macro REGFILE_BYPASS_EN enables same-cycle write-through reads.
module wb_regfile
    import pipeline_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    wb_regfile_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  wb_data;
    logic             commit;
    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [AW-1:0]    raddr [2];
    logic [XLEN-1:0]  rdata [2];

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .sel_i  (bus.wb_sel_W),
        .alu_i  (bus.alu_data_W),
        .mem_i  (bus.read_data_W),
        .pc4_i  (bus.pc_four_W),
        .data_o (wb_data)
    );

    // x0 writes are dropped here, so they are neither stored nor counted.
    assign commit          = bus.rd_wren_W & (bus.rd_addr_W != '0);
    assign bus.wb_data_W   = wb_data;
    assign bus.wb_commit_W = commit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[bus.rd_addr_W] <= wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.commit_cnt = cnt_q;
    assign raddr[0]       = bus.rs1_addr_D;
    assign raddr[1]       = bus.rs2_addr_D;

    // Both ports share one read path so identical addresses always return identical data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (raddr[p] != '0) begin
                rdata[p] = regs_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
                if (commit && (raddr[p] == bus.rd_addr_W)) begin
                    rdata[p] = wb_data;
                end
`endif
            end
            if (!i_rst_n) begin
                rdata[p] = '0;
            end
        end
    end

    assign bus.rs1_data_D = rdata[0];
    assign bus.rs2_data_D = rdata[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a 32-bit-counter instance for register behaviour and a
// 4-bit-counter instance for counter wrap. Expected values are hand-computed constants.
module tb_wb_regfile;
    import pipeline_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    wb_regfile_if #(.XLEN(32), .NREG(32), .CNT_W(32)) bus  ();
    wb_regfile_if #(.XLEN(32), .NREG(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_wb(input logic wren, input logic [4:0] rd, input wb_sel_e sel,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        bus.rd_wren_W   = wren;
        bus.rd_addr_W   = rd;
        bus.wb_sel_W    = sel;
        bus.alu_data_W  = alu;
        bus.read_data_W = mem;
        bus.pc_four_W   = pc4;
    endtask

    logic [31:0] exp_same;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        bus.rs1_addr_D   = 5'd0;
        bus.rs2_addr_D   = 5'd0;
        bus4.rd_wren_W   = 1'b0;
        bus4.rd_addr_W   = 5'd1;
        bus4.wb_sel_W    = WB_ALU;
        bus4.alu_data_W  = 32'h0000_0001;
        bus4.read_data_W = 32'h0;
        bus4.pc_four_W   = 32'h0;
        bus4.rs1_addr_D  = 5'd1;
        bus4.rs2_addr_D  = 5'd0;
        #3;

        check("reset_cnt", bus.commit_cnt, 32'h0);
        check("reset_cnt4", {28'h0, bus4.commit_cnt}, 32'h0);
        check("reset_rs1_x0", bus.rs1_data_D, 32'h0);

        // WB select and commit flag stay live while reset is held.
        drive_wb(1'b1, 5'd2, WB_ALU, 32'h0000_0055, 32'h0, 32'h0);
        #1;
        check("reset_wb_data_live", bus.wb_data_W, 32'h0000_0055);
        check("reset_wb_commit_live", {31'h0, bus.wb_commit_W}, 32'h1);
        tick();
        bus.rs1_addr_D = 5'd2;
        #1;
        check("reset_no_write_x2", bus.rs1_data_D, 32'h0);
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_release_x2", bus.rs1_data_D, 32'h0);
        check("post_release_cnt", bus.commit_cnt, 32'h0);

        // Test 1: write x5, then reset mid-run.
        drive_wb(1'b1, 5'd5, WB_ALU, 32'hDEAD_BEEF, 32'h0, 32'h0);
        bus.rs1_addr_D = 5'd5;
        tick();
        check("t1_x5_written", bus.rs1_data_D, 32'hDEAD_BEEF);
        check("t1_cnt_1", bus.commit_cnt, 32'h1);
        drive_wb(1'b1, 5'd6, WB_ALU, 32'h0000_6666, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t1_rst_x5_zero", bus.rs1_data_D, 32'h0);
        check("t1_rst_cnt_zero", bus.commit_cnt, 32'h0);
        tick();
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        bus.rs1_addr_D = 5'd6;
        bus.rs2_addr_D = 5'd5;
        #1;
        check("t1_x6_lost", bus.rs1_data_D, 32'h0);
        check("t1_x5_after", bus.rs2_data_D, 32'h0);
        check("t1_cnt_after", bus.commit_cnt, 32'h0);

        // Test 2: load write-back to x7.
        drive_wb(1'b1, 5'd7, WB_MEM, 32'hAAAA_0000, 32'h1234_5678, 32'h0000_0004);
        #1;
        check("t2_wb_data", bus.wb_data_W, 32'h1234_5678);
        check("t2_wb_commit", {31'h0, bus.wb_commit_W}, 32'h1);
        tick();
        drive_wb(1'b0, 5'd7, WB_ALU, 32'h0, 32'h0, 32'h0);
        bus.rs2_addr_D = 5'd7;
        #1;
        check("t2_x7", bus.rs2_data_D, 32'h1234_5678);
        check("t2_cnt", bus.commit_cnt, 32'h1);
        check("t2_no_wren_commit", {31'h0, bus.wb_commit_W}, 32'h0);
        tick();
        check("t2_no_wren_cnt", bus.commit_cnt, 32'h1);

        // Test 3: writes to x0 are dropped.
        drive_wb(1'b1, 5'd0, WB_ALU, 32'hFFFF_FFFF, 32'h0, 32'h0);
        bus.rs1_addr_D = 5'd0;
        #1;
        check("t3_commit_x0", {31'h0, bus.wb_commit_W}, 32'h0);
        tick();
        check("t3_x0_read", bus.rs1_data_D, 32'h0);
        check("t3_cnt_unchanged", bus.commit_cnt, 32'h1);

        // Test 4: same-cycle write and read of x3.
        drive_wb(1'b1, 5'd3, WB_ALU, 32'h1111_0000, 32'h0, 32'h0);
        tick();
        drive_wb(1'b1, 5'd3, WB_PC4, 32'h0, 32'h0, 32'hA5A5_A5A5);
        bus.rs1_addr_D = 5'd3;
        bus.rs2_addr_D = 5'd3;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h1111_0000;
`endif
        #1;
        check("t4_same_cycle_rs1", bus.rs1_data_D, exp_same);
        check("t4_same_cycle_rs2", bus.rs2_data_D, exp_same);
        tick();
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        #1;
        check("t4_next_cycle", bus.rs1_data_D, 32'hA5A5_A5A5);
        check("t4_cnt", bus.commit_cnt, 32'h3);

        // Test 5: reserved select writes zero over a nonzero value.
        drive_wb(1'b1, 5'd9, WB_ALU, 32'h0000_00FF, 32'h0, 32'h0);
        bus.rs1_addr_D = 5'd9;
        tick();
        check("t5_x9_pre", bus.rs1_data_D, 32'h0000_00FF);
        drive_wb(1'b1, 5'd9, WB_RSV, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        #1;
        check("t5_wb_data_rsv", bus.wb_data_W, 32'h0);
        tick();
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        #1;
        check("t5_x9_zero", bus.rs1_data_D, 32'h0);
        check("t5_cnt", bus.commit_cnt, 32'h5);

        // Highest register, and both ports on one register.
        drive_wb(1'b1, 5'd31, WB_MEM, 32'h0, 32'h8000_0001, 32'h0);
        tick();
        drive_wb(1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0);
        bus.rs1_addr_D = 5'd31;
        bus.rs2_addr_D = 5'd7;
        #1;
        check("x31_read", bus.rs1_data_D, 32'h8000_0001);
        check("x7_still", bus.rs2_data_D, 32'h1234_5678);
        bus.rs1_addr_D = 5'd7;
        #1;
        check("same_addr_rs1", bus.rs1_data_D, 32'h1234_5678);

        // Test 6: 4-bit commit counter wraps after 16 commits.
        bus4.rd_wren_W = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        check("t6_cnt4_max", {28'h0, bus4.commit_cnt}, 32'hF);
        tick();
        check("t6_cnt4_wrap", {28'h0, bus4.commit_cnt}, 32'h0);
        tick();
        bus4.rd_wren_W = 1'b0;
        check("t6_cnt4_after", {28'h0, bus4.commit_cnt}, 32'h1);
        check("t6_x1_cnt4", bus4.rs1_data_D, 32'h0000_0001);
        check("t6_cnt32_idle", bus.commit_cnt, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
